code_loader: RTL

- Writer side of the datapath's code-memory load port (code_w_en / code_addr_in / code_in) and owner of its run input.
- Receives a program image as a framed stream of 4-bit nibbles on a valid/ready handshake.
- Assembles the nibbles into instruction words, writes them to consecutive code addresses from 0, verifies a checksum, and only then asserts run.
- Sits between the external nibble source and the datapath inside the dibu top level.

---
 rtl/code_loader_pkg.sv | 21 ++
 rtl/code_loader_if.sv | 20 ++
 rtl/code_loader_nibble_assembler.sv | 57 +++++
 rtl/code_loader.sv | 135 +++++++++++++
 4 files changed

// File: rtl/code_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : code_loader_pkg
//  Description : Shared types and constants for the code memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package code_loader_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/code_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : code_loader_if
//  Description : Nibble stream valid/ready bundle feeding the code loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface code_loader_if;
  import code_loader_pkg::*;

  logic [NIB_W-1:0] nib_in;
  logic             nib_valid;
  logic             nib_ready;

  // Nibble source side
  modport master (output nib_in, output nib_valid, input nib_ready);
  // Loader side
  modport slave  (input nib_in, input nib_valid, output nib_ready);

endinterface
`default_nettype wire

// File: rtl/code_loader_nibble_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_assembler
//  Description : MSB-first nibble shift register with a nibble counter.
//                The word output already includes the nibble being shifted
//                in this cycle, so a consumer can capture the complete word
//                on the same edge that takes the final nibble.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_assembler
  import code_loader_pkg::*;
#(
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [NIB_W-1:0] nib,
  output logic [W-1:0]     word,
  output logic             last
);

  localparam int NIBS = W / NIB_W;
  localparam int CW   = (NIBS > 1) ? $clog2(NIBS) : 1;

  logic [W-1:0]  acc;
  logic [W-1:0]  shifted;
  logic [CW-1:0] cnt;

  generate
    if (W > NIB_W) begin : g_wide
      assign shifted = {acc[W-NIB_W-1:0], nib};
    end else begin : g_narrow
      assign shifted = nib;
    end
  endgenerate

  assign word = shift_en ? shifted : acc;
  assign last = shift_en && (cnt == CW'(NIBS - 1));

  // Shift register and nibble position; the counter wraps after the last nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      acc <= shifted;
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/code_loader.sv
`default_nettype none
// ============================================================================
//  Module      : code_loader
//  Description : Receives a framed nibble stream (LEN, words, CHK), writes
//                the words to consecutive code addresses from 0 and raises
//                run once the XOR checksum matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module code_loader
  import code_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  code_loader_if.slave       nib_if,
  output logic               code_w_en,
  output logic [ADDR_W-1:0]  code_addr_in,
  output logic [INSTR_W-1:0] code_in,
  output logic               run,
  output logic               busy,
  output logic               err
);

  localparam int LEN_NIBS  = ADDR_W / NIB_W;
  localparam int WORD_NIBS = INSTR_W / NIB_W;

  state_t             state;
  state_t             state_next;
  logic               ready;
  logic               xfer;
  logic               len_shift;
  logic               data_shift;
  logic [ADDR_W-1:0]  len_word;
  logic               len_last;
  logic [INSTR_W-1:0] data_word;
  logic               data_last;
  logic [ADDR_W:0]    addr_cnt;     // one extra bit so LEN = 2^ADDR_W-1 never wraps
  logic               word_is_last;
  logic [NIB_W-1:0]   xor_acc;

  assign ready            = (state == LEN) || (state == DATA) || (state == CHK);
  assign nib_if.nib_ready = ready;
  assign xfer             = nib_if.nib_valid && ready;

  // start takes priority: a nibble offered in the start cycle is dropped
  assign len_shift    = xfer && !start && (state == LEN);
  assign data_shift   = xfer && !start && (state == DATA);
  assign word_is_last = (addr_cnt == {1'b0, len_word});

  assign run  = (state == RUN);
  assign err  = (state == ERR);
  assign busy = ready;

  nibble_assembler #(.W(LEN_NIBS * NIB_W)) u_len_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .shift_en (len_shift),
    .nib      (nib_if.nib_in),
    .word     (len_word),
    .last     (len_last)
  );

  nibble_assembler #(.W(WORD_NIBS * NIB_W)) u_data_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .shift_en (data_shift),
    .nib      (nib_if.nib_in),
    .word     (data_word),
    .last     (data_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start restarts the load from any state
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = LEN;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        LEN:  if (len_last) state_next = DATA;
        DATA: if (data_last && word_is_last) state_next = CHK;
        CHK:  if (xfer) state_next = (nib_if.nib_in == xor_acc) ? RUN : ERR;
        RUN:  state_next = RUN;
        ERR:  state_next = ERR;
        default: state_next = IDLE;
      endcase
    end
  end

  // Write port: one-cycle strobe after each completed word, address counts up
  always_ff @(posedge clk) begin
    if (rst) begin
      code_w_en    <= 1'b0;
      code_addr_in <= '0;
      code_in      <= '0;
      addr_cnt     <= '0;
    end else begin
      code_w_en <= data_last;
      if (data_last) begin
        code_addr_in <= addr_cnt[ADDR_W-1:0];
        code_in      <= data_word;
      end
      if (start) begin
        addr_cnt <= '0;
      end else if (data_last) begin
        addr_cnt <= addr_cnt + 1'b1;
      end
    end
  end

  // Running XOR over LEN and data nibbles
  always_ff @(posedge clk) begin
    if (rst || start) begin
      xor_acc <= '0;
    end else if (len_shift || data_shift) begin
      xor_acc <= xor_acc ^ nib_if.nib_in;
    end
  end

endmodule
`default_nettype wire
